instruction_parse_lut: RTL and testbench
========================================

# instruction_parse_lut

Multicycle control unit for the 32-bit MIPS-subset CPU. It splits the instruction-register word into its fields and runs the per-instruction state machine. Each cycle it drives every write enable, mux select and ALU operation in the datapath: PC, IR, A/B, ALU register, BEN register, register file and memory. It sits beside the datapath and feeds the ALU and the 4:1 operand/PC muxes.

## Interface
Parameters: none. The widths below are fixed.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- instruction  in  32  IR contents
- rs, rt, rd, shamt  out  5 each  fields [25:21], [20:16], [15:11], [10:6]
- funct  out  6  [5:0]
- imm  out  16  [15:0]
- address  out  26  [25:0]
- state  out  6  current state
- newstatus  out  6  next state
- PC_WE, IR_WE, A_WE, B_WE, BEN, Reg_WE, Mem_WE  out  1 each  register and memory write enables
- MemIn  out  1  memory address select: 0 = PC, 1 = ALU register
- RegIn  out  1  register write data: 0 = MDR, 1 = ALU register
- Dst  out  1  destination register: 0 = rd, 1 = rt
- jal  out  1  forces write address 31
- Immer  out  1  forces imm to 0; always 0 in this design
- BEQBNE  out  1  0 = take branch on zero, 1 = take branch on not-zero
- ALUSrcA  out  2  0 = PC, 1 = A, 2 = BEN register, 3 = 0
- ALUSrcB  out  2  0 = sext(imm)<<2, 1 = sext(imm), 2 = B, 3 = 4
- ALUOp  out  3  0 = ADD, 1 = SUB, 2 = XOR, 3 = SLT, 4 = AND, 5 = NAND, 6 = NOR, 7 = OR
- PCSrc  out  2  0 = branch select, 1 = jump concat, 2 = live ALU output, 3 = ALU register

## Operation
- Field outputs are purely combinational from `instruction`.
- Control outputs are Moore outputs of `state`. Any output not listed for a state is 0.
- Supported instructions:
  - LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, ADDI 0x08, XORI 0x0E
  - R-type 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08
- States and actions:
  - FETCH=1: IR_WE, PC_WE, ALUSrcA=0, ALUSrcB=3, ADD, PCSrc=2. Next DECODE.
  - DECODE=2: A_WE, B_WE, BEN (latches PC+4), ALUSrcA=0, ALUSrcB=0, ADD (branch target into the ALU register). Next state by opcode/funct.
  - MEMADR=3: ALUSrcA=1, ALUSrcB=1, ADD. Next LWRD for LW, SWWR for SW.
  - LWRD=4: MemIn=1. Next LWWB.
  - LWWB=5: Reg_WE, RegIn=0, Dst=1. Next FETCH.
  - SWWR=6: Mem_WE, MemIn=1. Next FETCH.
  - REX=7: ALUSrcA=1, ALUSrcB=2, ALUOp from funct (ADD, SUB, SLT). Next RWB.
  - RWB=8: Reg_WE, RegIn=1, Dst=0. Next FETCH.
  - IEX=9: ALUSrcA=1, ALUSrcB=1, ADD for ADDI, XOR for XORI. Next IWB.
  - IWB=10: Reg_WE, RegIn=1, Dst=1. Next FETCH.
  - BR=11: ALUSrcA=1, ALUSrcB=2, SUB, PC_WE, PCSrc=0, BEQBNE=(opcode==BNE). Taken selects the ALU register (target); not taken selects the BEN register (PC+4). Next FETCH.
  - JMP=12: PC_WE, PCSrc=1. Next FETCH.
  - JALLINK=13: ALUSrcA=2, ALUSrcB=3, ADD. The link value is PC+8, following the MIPS convention. Next JALWB.
  - JALWB=14: Reg_WE, RegIn=1, jal, PC_WE, PCSrc=1. Next FETCH.
  - JR=15: ALUSrcA=1, ALUSrcB=2, ADD (rs + $zero), PC_WE, PCSrc=2. Next FETCH.
- An unknown opcode or funct, or an unused state encoding, goes to FETCH with all enables 0.

## Timing
- The state register updates on the rising clk edge to `newstatus`.
- While reset is high: `newstatus`=FETCH and every write enable is forced to 0. After the next edge, `state`=FETCH.
- Reset asserted mid-instruction aborts it at the next edge; no further writes occur.
- Cycles per instruction: LW 5, SW 4, R-type/ADDI/XORI 4, BEQ/BNE 3, J 3, JAL 4, JR 3.
- Decode depends only on `instruction` latched by IR_WE in FETCH; it is stable from DECODE on.

## Structure
- A shared package holds:
  - state encodings
  - opcode and funct constants
  - ALUOp codes
  - ALUSrcA, ALUSrcB and PCSrc mux codes
- One natural sub-module: `instr_fields`, the combinational field splitter.

## Test plan
- Reset held for 2 cycles, then released -> state=1, IR_WE=1, PC_WE=1, ALUSrcB=3, ALUOp=0, PCSrc=2.
- instruction=0x8C430004 (LW $3,4($2)) -> states 1,2,3,4,5. In state 5: Reg_WE=1, Dst=1, RegIn=0. rs=2, rt=3, imm=4.
- instruction=0x00430820 (ADD $1,$2,$3) -> states 1,2,7,8. ALUOp=0 in state 7; Dst=0, Reg_WE=1 in state 8. For funct 0x2A, ALUOp=3.
- instruction=0x14220003 (BNE) -> states 1,2,11. BEQBNE=1, ALUOp=1, PC_WE=1, PCSrc=0. For BEQ 0x10220003, BEQBNE=0.
- instruction=0x0C000010 (JAL) -> states 1,2,13,14. address=0x10, jal=1, PCSrc=1. For opcode 0x3F -> state 2 then 1, no enables.
- Reset asserted while in state 4 -> next state 1, and Mem_WE and Reg_WE never assert.

Source files
------------

// File: rtl/instruction_parse_lut_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_parse_lut_pkg
//  Description : Shared definitions for the multicycle MIPS-subset control
//                unit: state encodings, opcode/funct constants, ALU operation
//                codes and datapath mux select codes.
//  Revision    : 1.0  initial release
// ============================================================================
package instruction_parse_lut_pkg;

    // Controller states (6-bit encoding exported on the state port)
    typedef enum logic [5:0] {
        S_FETCH   = 6'd1,
        S_DECODE  = 6'd2,
        S_MEMADR  = 6'd3,
        S_LWRD    = 6'd4,
        S_LWWB    = 6'd5,
        S_SWWR    = 6'd6,
        S_REX     = 6'd7,
        S_RWB     = 6'd8,
        S_IEX     = 6'd9,
        S_IWB     = 6'd10,
        S_BR      = 6'd11,
        S_JMP     = 6'd12,
        S_JALLINK = 6'd13,
        S_JALWB   = 6'd14,
        S_JR      = 6'd15
    } state_t;

    // Opcodes
    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_JAL   = 6'h03;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_BNE   = 6'h05;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;
    localparam logic [5:0] C_OP_XORI  = 6'h0E;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] C_FN_JR    = 6'h08;
    localparam logic [5:0] C_FN_ADD   = 6'h20;
    localparam logic [5:0] C_FN_SUB   = 6'h22;
    localparam logic [5:0] C_FN_SLT   = 6'h2A;

    // ALU operations
    localparam logic [2:0] C_ALU_ADD  = 3'd0;
    localparam logic [2:0] C_ALU_SUB  = 3'd1;
    localparam logic [2:0] C_ALU_XOR  = 3'd2;
    localparam logic [2:0] C_ALU_SLT  = 3'd3;
    localparam logic [2:0] C_ALU_AND  = 3'd4;
    localparam logic [2:0] C_ALU_NAND = 3'd5;
    localparam logic [2:0] C_ALU_NOR  = 3'd6;
    localparam logic [2:0] C_ALU_OR   = 3'd7;

    // ALU operand A select
    localparam logic [1:0] C_SRCA_PC   = 2'd0;
    localparam logic [1:0] C_SRCA_A    = 2'd1;
    localparam logic [1:0] C_SRCA_BEN  = 2'd2;
    localparam logic [1:0] C_SRCA_ZERO = 2'd3;

    // ALU operand B select
    localparam logic [1:0] C_SRCB_SEXT_SH2 = 2'd0;
    localparam logic [1:0] C_SRCB_SEXT     = 2'd1;
    localparam logic [1:0] C_SRCB_B        = 2'd2;
    localparam logic [1:0] C_SRCB_FOUR     = 2'd3;

    // Next-PC select
    localparam logic [1:0] C_PCSRC_BRANCH = 2'd0;
    localparam logic [1:0] C_PCSRC_JUMP   = 2'd1;
    localparam logic [1:0] C_PCSRC_ALU    = 2'd2;
    localparam logic [1:0] C_PCSRC_ALUREG = 2'd3;

    // ALU operation for a supported R-type arithmetic funct
    function automatic logic [2:0] alu_op_for_funct(input logic [5:0] fn);
        case (fn)
            C_FN_SUB: alu_op_for_funct = C_ALU_SUB;
            C_FN_SLT: alu_op_for_funct = C_ALU_SLT;
            default:  alu_op_for_funct = C_ALU_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_parse_lut_instr_fields.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fields
//  Description : Combinational splitter of the 32-bit instruction word.
//  Ports       : instruction (in)  IR contents
//                opcode/rs/rt/rd/shamt/funct/imm/address (out) fields
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fields (
    input  logic [31:0] instruction,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] address
);

    assign opcode  = instruction[31:26];
    assign rs      = instruction[25:21];
    assign rt      = instruction[20:16];
    assign rd      = instruction[15:11];
    assign shamt   = instruction[10:6];
    assign funct   = instruction[5:0];
    assign imm     = instruction[15:0];
    assign address = instruction[25:0];

endmodule
`default_nettype wire

// File: rtl/instruction_parse_lut.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_parse_lut
//  Description : Multicycle control unit for the 32-bit MIPS-subset CPU.
//                Splits the IR into fields and runs the per-instruction
//                Moore state machine driving all datapath controls.
//  Ports       : clk, reset (sync, active-high), instruction (IR contents)
//                rs/rt/rd/shamt/funct/imm/address : instruction fields
//                state/newstatus                  : current / next state
//                *_WE, BEN                        : write enables
//                MemIn, RegIn, Dst, jal, Immer,
//                BEQBNE, ALUSrcA, ALUSrcB, ALUOp,
//                PCSrc                            : datapath selects
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_parse_lut
    import instruction_parse_lut_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] address,
    output logic [5:0]  state,
    output logic [5:0]  newstatus,
    output logic        PC_WE,
    output logic        IR_WE,
    output logic        A_WE,
    output logic        B_WE,
    output logic        BEN,
    output logic        Reg_WE,
    output logic        Mem_WE,
    output logic        MemIn,
    output logic        RegIn,
    output logic        Dst,
    output logic        jal,
    output logic        Immer,
    output logic        BEQBNE,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  PCSrc
);

    logic [5:0] w_opcode;
    state_t     r_state;
    state_t     w_next;
    state_t     w_newstatus;

    logic w_pc_we, w_ir_we, w_a_we, w_b_we, w_ben, w_reg_we, w_mem_we;

    instr_fields u_fields (
        .instruction (instruction),
        .opcode      (w_opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm         (imm),
        .address     (address)
    );

    // Reset acts through the next-state path so the register needs no
    // separate reset branch: it always loads whatever newstatus shows.
    assign w_newstatus = reset ? S_FETCH : w_next;

    always_ff @(posedge clk) begin
        r_state <= w_newstatus;
    end

    always_comb begin
        w_next   = S_FETCH;
        w_pc_we  = 1'b0;
        w_ir_we  = 1'b0;
        w_a_we   = 1'b0;
        w_b_we   = 1'b0;
        w_ben    = 1'b0;
        w_reg_we = 1'b0;
        w_mem_we = 1'b0;
        MemIn    = 1'b0;
        RegIn    = 1'b0;
        Dst      = 1'b0;
        jal      = 1'b0;
        BEQBNE   = 1'b0;
        ALUSrcA  = C_SRCA_PC;
        ALUSrcB  = C_SRCB_SEXT_SH2;
        ALUOp    = C_ALU_ADD;
        PCSrc    = C_PCSRC_BRANCH;

        case (r_state)
            S_FETCH: begin
                w_ir_we = 1'b1;
                w_pc_we = 1'b1;
                ALUSrcA = C_SRCA_PC;
                ALUSrcB = C_SRCB_FOUR;
                PCSrc   = C_PCSRC_ALU;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                // PC already holds PC+4; BEN keeps it for the not-taken
                // branch and the JAL link, the ALU register gets the target.
                w_a_we  = 1'b1;
                w_b_we  = 1'b1;
                w_ben   = 1'b1;
                ALUSrcA = C_SRCA_PC;
                ALUSrcB = C_SRCB_SEXT_SH2;
                case (w_opcode)
                    C_OP_LW, C_OP_SW:     w_next = S_MEMADR;
                    C_OP_ADDI, C_OP_XORI: w_next = S_IEX;
                    C_OP_BEQ, C_OP_BNE:   w_next = S_BR;
                    C_OP_J:               w_next = S_JMP;
                    C_OP_JAL:             w_next = S_JALLINK;
                    C_OP_RTYPE: begin
                        case (funct)
                            C_FN_ADD, C_FN_SUB, C_FN_SLT: w_next = S_REX;
                            C_FN_JR:                      w_next = S_JR;
                            default:                      w_next = S_FETCH;
                        endcase
                    end
                    default:              w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = C_SRCA_A;
                ALUSrcB = C_SRCB_SEXT;
                if (w_opcode == C_OP_LW) begin
                    w_next = S_LWRD;
                end else if (w_opcode == C_OP_SW) begin
                    w_next = S_SWWR;
                end
            end
            S_LWRD: begin
                MemIn  = 1'b1;
                w_next = S_LWWB;
            end
            S_LWWB: begin
                w_reg_we = 1'b1;
                Dst      = 1'b1;
            end
            S_SWWR: begin
                w_mem_we = 1'b1;
                MemIn    = 1'b1;
            end
            S_REX: begin
                ALUSrcA = C_SRCA_A;
                ALUSrcB = C_SRCB_B;
                ALUOp   = alu_op_for_funct(funct);
                w_next  = S_RWB;
            end
            S_RWB: begin
                w_reg_we = 1'b1;
                RegIn    = 1'b1;
            end
            S_IEX: begin
                ALUSrcA = C_SRCA_A;
                ALUSrcB = C_SRCB_SEXT;
                ALUOp   = (w_opcode == C_OP_XORI) ? C_ALU_XOR : C_ALU_ADD;
                w_next  = S_IWB;
            end
            S_IWB: begin
                w_reg_we = 1'b1;
                RegIn    = 1'b1;
                Dst      = 1'b1;
            end
            S_BR: begin
                // A-B through the ALU; the datapath picks the ALU register
                // (target) or BEN (PC+4) from the zero flag and BEQBNE.
                ALUSrcA = C_SRCA_A;
                ALUSrcB = C_SRCB_B;
                ALUOp   = C_ALU_SUB;
                w_pc_we = 1'b1;
                PCSrc   = C_PCSRC_BRANCH;
                BEQBNE  = (w_opcode == C_OP_BNE);
            end
            S_JMP: begin
                w_pc_we = 1'b1;
                PCSrc   = C_PCSRC_JUMP;
            end
            S_JALLINK: begin
                // BEN holds PC+4, so +4 gives the PC+8 link value
                ALUSrcA = C_SRCA_BEN;
                ALUSrcB = C_SRCB_FOUR;
                w_next  = S_JALWB;
            end
            S_JALWB: begin
                w_reg_we = 1'b1;
                RegIn    = 1'b1;
                jal      = 1'b1;
                w_pc_we  = 1'b1;
                PCSrc    = C_PCSRC_JUMP;
            end
            S_JR: begin
                ALUSrcA = C_SRCA_A;
                ALUSrcB = C_SRCB_B;
                w_pc_we = 1'b1;
                PCSrc   = C_PCSRC_ALU;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign state     = r_state;
    assign newstatus = w_newstatus;
    assign Immer     = 1'b0;

    // Enables are suppressed during reset so an aborted instruction
    // cannot commit anything on the reset edge.
    assign PC_WE  = w_pc_we  & ~reset;
    assign IR_WE  = w_ir_we  & ~reset;
    assign A_WE   = w_a_we   & ~reset;
    assign B_WE   = w_b_we   & ~reset;
    assign BEN    = w_ben    & ~reset;
    assign Reg_WE = w_reg_we & ~reset;
    assign Mem_WE = w_mem_we & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_instruction_parse_lut.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_parse_lut
//  Description : Self-checking bench for instruction_parse_lut. A table of
//                per-cycle {instruction, state, next state, control word}
//                records is stepped one clock per row; reset and field
//                corner cases are hand-written sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_parse_lut;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] address;
    logic [5:0]  state, newstatus;
    logic        PC_WE, IR_WE, A_WE, B_WE, BEN, Reg_WE, Mem_WE;
    logic        MemIn, RegIn, Dst, jal, Immer, BEQBNE;
    logic [1:0]  ALUSrcA, ALUSrcB, PCSrc;
    logic [2:0]  ALUOp;

    int n_cmp = 0;
    int n_err = 0;

    instruction_parse_lut dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm         (imm),
        .address     (address),
        .state       (state),
        .newstatus   (newstatus),
        .PC_WE       (PC_WE),
        .IR_WE       (IR_WE),
        .A_WE        (A_WE),
        .B_WE        (B_WE),
        .BEN         (BEN),
        .Reg_WE      (Reg_WE),
        .Mem_WE      (Mem_WE),
        .MemIn       (MemIn),
        .RegIn       (RegIn),
        .Dst         (Dst),
        .jal         (jal),
        .Immer       (Immer),
        .BEQBNE      (BEQBNE),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSrc       (PCSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word layout:
    // {PC_WE,IR_WE,A_WE,B_WE,BEN,Reg_WE,Mem_WE, MemIn,RegIn,Dst,jal,Immer,BEQBNE,
    //  ALUSrcA, ALUSrcB, ALUOp, PCSrc}
    logic [21:0] w_ctrl;
    assign w_ctrl = {PC_WE, IR_WE, A_WE, B_WE, BEN, Reg_WE, Mem_WE,
                     MemIn, RegIn, Dst, jal, Immer, BEQBNE,
                     ALUSrcA, ALUSrcB, ALUOp, PCSrc};

    function automatic logic [21:0] mk(input logic [6:0] en, input logic [5:0] fl,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] op, input logic [1:0] pcs);
        mk = {en, fl, sa, sb, op, pcs};
    endfunction

    typedef struct {
        logic [31:0] ins;
        logic [5:0]  st;
        logic [5:0]  nx;
        logic [21:0] ctrl;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [31:0] ins, input logic [5:0] st,
                       input logic [5:0] nx, input logic [21:0] c);
        vec_t v;
        v.ins = ins; v.st = st; v.nx = nx; v.ctrl = c;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed control words per state
    logic [21:0] C_FETCH, C_DECODE, C_MEMADR, C_LWRD, C_LWWB, C_SWWR;
    logic [21:0] C_REX_ADD, C_REX_SUB, C_REX_SLT, C_RWB, C_IEX_ADD, C_IEX_XOR, C_IWB;
    logic [21:0] C_BEQ, C_BNE, C_JMP, C_JALLINK, C_JALWB, C_JR;

    initial begin
        C_FETCH   = mk(7'b1100000, 6'b000000, 2'd0, 2'd3, 3'd0, 2'd2);
        C_DECODE  = mk(7'b0011100, 6'b000000, 2'd0, 2'd0, 3'd0, 2'd0);
        C_MEMADR  = mk(7'b0000000, 6'b000000, 2'd1, 2'd1, 3'd0, 2'd0);
        C_LWRD    = mk(7'b0000000, 6'b100000, 2'd0, 2'd0, 3'd0, 2'd0);
        C_LWWB    = mk(7'b0000010, 6'b001000, 2'd0, 2'd0, 3'd0, 2'd0);
        C_SWWR    = mk(7'b0000001, 6'b100000, 2'd0, 2'd0, 3'd0, 2'd0);
        C_REX_ADD = mk(7'b0000000, 6'b000000, 2'd1, 2'd2, 3'd0, 2'd0);
        C_REX_SUB = mk(7'b0000000, 6'b000000, 2'd1, 2'd2, 3'd1, 2'd0);
        C_REX_SLT = mk(7'b0000000, 6'b000000, 2'd1, 2'd2, 3'd3, 2'd0);
        C_RWB     = mk(7'b0000010, 6'b010000, 2'd0, 2'd0, 3'd0, 2'd0);
        C_IEX_ADD = mk(7'b0000000, 6'b000000, 2'd1, 2'd1, 3'd0, 2'd0);
        C_IEX_XOR = mk(7'b0000000, 6'b000000, 2'd1, 2'd1, 3'd2, 2'd0);
        C_IWB     = mk(7'b0000010, 6'b011000, 2'd0, 2'd0, 3'd0, 2'd0);
        C_BEQ     = mk(7'b1000000, 6'b000000, 2'd1, 2'd2, 3'd1, 2'd0);
        C_BNE     = mk(7'b1000000, 6'b000001, 2'd1, 2'd2, 3'd1, 2'd0);
        C_JMP     = mk(7'b1000000, 6'b000000, 2'd0, 2'd0, 3'd0, 2'd1);
        C_JALLINK = mk(7'b0000000, 6'b000000, 2'd2, 2'd3, 3'd0, 2'd0);
        C_JALWB   = mk(7'b1000010, 6'b010100, 2'd0, 2'd0, 3'd0, 2'd1);
        C_JR      = mk(7'b1000000, 6'b000000, 2'd1, 2'd2, 3'd0, 2'd2);

        // LW $3,4($2): 5 cycles
        add(32'h8C430004, 6'd1,  6'd2,  C_FETCH);
        add(32'h8C430004, 6'd2,  6'd3,  C_DECODE);
        add(32'h8C430004, 6'd3,  6'd4,  C_MEMADR);
        add(32'h8C430004, 6'd4,  6'd5,  C_LWRD);
        add(32'h8C430004, 6'd5,  6'd1,  C_LWWB);
        // SW $3,4($2): 4 cycles
        add(32'hAC430004, 6'd1,  6'd2,  C_FETCH);
        add(32'hAC430004, 6'd2,  6'd3,  C_DECODE);
        add(32'hAC430004, 6'd3,  6'd6,  C_MEMADR);
        add(32'hAC430004, 6'd6,  6'd1,  C_SWWR);
        // ADD $1,$2,$3
        add(32'h00430820, 6'd1,  6'd2,  C_FETCH);
        add(32'h00430820, 6'd2,  6'd7,  C_DECODE);
        add(32'h00430820, 6'd7,  6'd8,  C_REX_ADD);
        add(32'h00430820, 6'd8,  6'd1,  C_RWB);
        // SUB
        add(32'h00430822, 6'd1,  6'd2,  C_FETCH);
        add(32'h00430822, 6'd2,  6'd7,  C_DECODE);
        add(32'h00430822, 6'd7,  6'd8,  C_REX_SUB);
        add(32'h00430822, 6'd8,  6'd1,  C_RWB);
        // SLT
        add(32'h0043082A, 6'd1,  6'd2,  C_FETCH);
        add(32'h0043082A, 6'd2,  6'd7,  C_DECODE);
        add(32'h0043082A, 6'd7,  6'd8,  C_REX_SLT);
        add(32'h0043082A, 6'd8,  6'd1,  C_RWB);
        // ADDI / XORI
        add(32'h20410005, 6'd1,  6'd2,  C_FETCH);
        add(32'h20410005, 6'd2,  6'd9,  C_DECODE);
        add(32'h20410005, 6'd9,  6'd10, C_IEX_ADD);
        add(32'h20410005, 6'd10, 6'd1,  C_IWB);
        add(32'h38410005, 6'd1,  6'd2,  C_FETCH);
        add(32'h38410005, 6'd2,  6'd9,  C_DECODE);
        add(32'h38410005, 6'd9,  6'd10, C_IEX_XOR);
        add(32'h38410005, 6'd10, 6'd1,  C_IWB);
        // BNE / BEQ
        add(32'h14220003, 6'd1,  6'd2,  C_FETCH);
        add(32'h14220003, 6'd2,  6'd11, C_DECODE);
        add(32'h14220003, 6'd11, 6'd1,  C_BNE);
        add(32'h10220003, 6'd1,  6'd2,  C_FETCH);
        add(32'h10220003, 6'd2,  6'd11, C_DECODE);
        add(32'h10220003, 6'd11, 6'd1,  C_BEQ);
        // J
        add(32'h08000010, 6'd1,  6'd2,  C_FETCH);
        add(32'h08000010, 6'd2,  6'd12, C_DECODE);
        add(32'h08000010, 6'd12, 6'd1,  C_JMP);
        // JAL
        add(32'h0C000010, 6'd1,  6'd2,  C_FETCH);
        add(32'h0C000010, 6'd2,  6'd13, C_DECODE);
        add(32'h0C000010, 6'd13, 6'd14, C_JALLINK);
        add(32'h0C000010, 6'd14, 6'd1,  C_JALWB);
        // JR $2
        add(32'h00400008, 6'd1,  6'd2,  C_FETCH);
        add(32'h00400008, 6'd2,  6'd15, C_DECODE);
        add(32'h00400008, 6'd15, 6'd1,  C_JR);
        // Unknown opcode 0x3F and unknown funct 0x21: DECODE then FETCH
        add(32'hFC000000, 6'd1,  6'd2,  C_FETCH);
        add(32'hFC000000, 6'd2,  6'd1,  C_DECODE);
        add(32'h00430821, 6'd1,  6'd2,  C_FETCH);
        add(32'h00430821, 6'd2,  6'd1,  C_DECODE);
        add(32'h00430821, 6'd1,  6'd2,  C_FETCH);
    end

    initial begin
        reset       = 1'b1;
        instruction = 32'h0;

        // Reset held two cycles; enables stay low throughout
        tick();
        check("rst_newstatus", 32'(newstatus), 32'd1);
        check("rst_enables_c1", 32'(w_ctrl[21:15]), 32'd0);
        check("rst_state_c1", 32'(state), 32'd1);
        tick();
        check("rst_enables_c2", 32'(w_ctrl[21:15]), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_state", 32'(state), 32'd1);
        check("post_rst_ctrl", 32'(w_ctrl), 32'(C_FETCH));

        // Field splitting
        instruction = 32'h8C430004;
        #1;
        check("lw_rs", 32'(rs), 32'd2);
        check("lw_rt", 32'(rt), 32'd3);
        check("lw_imm", 32'(imm), 32'd4);
        instruction = 32'h00430820;
        #1;
        check("add_rd", 32'(rd), 32'd1);
        check("add_shamt", 32'(shamt), 32'd0);
        check("add_funct", 32'(funct), 32'h20);
        instruction = 32'h0C000010;
        #1;
        check("jal_address", 32'(address), 32'h10);
        check("immer", 32'(Immer), 32'd0);
        instruction = 32'hFFFF07C0;
        #1;
        check("ones_shamt", 32'(shamt), 32'h1F);
        check("ones_rs", 32'(rs), 32'h1F);

        // Table walk, one row per clock
        foreach (tbl[i]) begin
            instruction = tbl[i].ins;
            #1;
            check($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
            check($sformatf("row%0d_next", i), 32'(newstatus), 32'(tbl[i].nx));
            check($sformatf("row%0d_ctrl", i), 32'(w_ctrl), 32'(tbl[i].ctrl));
            tick();
        end

        // Table ends in DECODE; let the machine reach LWRD for an LW
        instruction = 32'h8C430004;
        #1;
        check("abort_pre_state2", 32'(state), 32'd2);
        tick();
        check("abort_pre_state3", 32'(state), 32'd3);
        tick();
        check("abort_pre_state4", 32'(state), 32'd4);
        reset = 1'b1;
        #1;
        check("abort_newstatus", 32'(newstatus), 32'd1);
        check("abort_reg_we", 32'(Reg_WE), 32'd0);
        check("abort_mem_we", 32'(Mem_WE), 32'd0);
        tick();
        check("abort_state", 32'(state), 32'd1);
        check("abort_reg_we_c2", 32'(Reg_WE), 32'd0);
        check("abort_mem_we_c2", 32'(Mem_WE), 32'd0);
        reset = 1'b0;
        #1;
        check("abort_resume_ctrl", 32'(w_ctrl), 32'(C_FETCH));
        tick();
        check("abort_resume_state", 32'(state), 32'd2);
        check("abort_resume_reg_we", 32'(Reg_WE), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
